fpu_issue: RTL and testbench

FPU_ISSUE -- requirements
Module: fpu_issue

---
 rtl/fpu_pkg.sv | 36 +++
 rtl/fpu_inst_decode.sv | 65 ++++++
 rtl/fpu_issue.sv | 84 ++++++++
 tb/tb_fpu_issue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared RV32F issue-stage definitions: encodings, decode bundle and
// default write-back latency.
package fpu_pkg;

  localparam int REG_W      = 5;
  localparam int NREG       = 1 << REG_W;
  localparam int WB_LAT_DEF = 5;

  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [6:0] F7_FADD   = 7'b0000000;
  localparam logic [6:0] F7_FSUB   = 7'b0000100;
  localparam logic [6:0] F7_FMUL   = 7'b0001000;
  localparam logic [6:0] F7_FMV_WX = 7'b1111000;
  localparam logic [6:0] F7_FMV_XW = 7'b1110000;

  typedef struct packed {
    logic             reg_write;
    logic             is_load;
    logic             is_adsb;
    logic             is_sub;
    logic             is_mult;
    logic             is_itof;
    logic             use_rs1;
    logic             use_rs2;
    logic             illegal;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } fpu_dec_t;

endpackage

// File: rtl/fpu_inst_decode.sv
// Pure combinational RV32F decoder: op flags, FP source use and
// register fields.
module fpu_inst_decode
  import fpu_pkg::*;
(
  input  logic [31:0] inst,
  output fpu_dec_t    dec
);

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       op_fp;
  logic       word;

  assign opc   = inst[6:0];
  assign f7    = inst[31:25];
  assign f3    = inst[14:12];
  assign op_fp = (opc == OPC_OP_FP);
  assign word  = (f3 == F3_WORD);

  always_comb begin
    dec     = '0;
    dec.rd  = inst[11:7];
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
    unique case (1'b1)
      (opc == OPC_LOAD_FP) && word: begin
        dec.is_load   = 1'b1;
        dec.reg_write = 1'b1;
      end
      (opc == OPC_STORE_FP) && word: begin
        dec.use_rs2 = 1'b1;
      end
      op_fp && (f7 == F7_FADD): begin
        dec.is_adsb   = 1'b1;
        dec.reg_write = 1'b1;
        dec.use_rs1   = 1'b1;
        dec.use_rs2   = 1'b1;
      end
      op_fp && (f7 == F7_FSUB): begin
        dec.is_adsb   = 1'b1;
        dec.is_sub    = 1'b1;
        dec.reg_write = 1'b1;
        dec.use_rs1   = 1'b1;
        dec.use_rs2   = 1'b1;
      end
      op_fp && (f7 == F7_FMUL): begin
        dec.is_mult   = 1'b1;
        dec.reg_write = 1'b1;
        dec.use_rs1   = 1'b1;
        dec.use_rs2   = 1'b1;
      end
      op_fp && (f7 == F7_FMV_WX): begin
        dec.is_itof   = 1'b1;
        dec.reg_write = 1'b1;
      end
      op_fp && (f7 == F7_FMV_XW): begin
        dec.use_rs1 = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fpu_issue.sv
// FPU issue stage: per-register latency scoreboard, RAW stall and
// stall performance counter.
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int unsigned WB_LAT = WB_LAT_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             inst_valid,
  output logic             stall,
  output logic             reg_write,
  output logic             is_load,
  output logic             is_adsb,
  output logic             is_sub,
  output logic             is_mult,
  output logic             is_itof,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int SB_W = $clog2(WB_LAT + 1);

  fpu_dec_t dec;

  logic [SB_W-1:0]  sb_q [NREG];
  logic [SB_W-1:0]  sb_d [NREG];
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic hz1;
  logic hz2;
  logic live;
  logic issue;

  fpu_inst_decode u_dec (
    .inst (inst),
    .dec  (dec)
  );

  assign hz1   = dec.use_rs1 && (sb_q[dec.rs1] != '0);
  assign hz2   = dec.use_rs2 && (sb_q[dec.rs2] != '0);
  assign live  = inst_valid && !rst;
  assign stall = live && (hz1 || hz2);
  assign issue = live && !(hz1 || hz2) && !dec.illegal;

  assign illegal   = live && dec.illegal;
  assign reg_write = issue && dec.reg_write;
  assign is_load   = issue && dec.is_load;
  assign is_adsb   = issue && dec.is_adsb;
  assign is_sub    = issue && dec.is_sub;
  assign is_mult   = issue && dec.is_mult;
  assign is_itof   = issue && dec.is_itof;
  assign stall_cnt = stall_cnt_q;

  // The issue cycle is the first latency cycle, so the counter holds
  // the cycles still to wait; zero means the result can be read.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      sb_d[i] = (sb_q[i] != '0) ? sb_q[i] - SB_W'(1) : '0;
    end
    if (reg_write) begin
      sb_d[dec.rd] = SB_W'(WB_LAT - 1);
    end
    stall_cnt_d = stall_cnt_q + CNT_W'(stall);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        sb_q[i] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        sb_q[i] <= sb_d[i];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// Directed-vector bench for fpu_issue with hand-computed expectations.
module tb_fpu_issue;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stall;
  logic        reg_write;
  logic        is_load;
  logic        is_adsb;
  logic        is_sub;
  logic        is_mult;
  logic        is_itof;
  logic        illegal;
  logic [31:0] stall_cnt;

  int checks;
  int errors;

  fpu_issue #(.WB_LAT(5), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .inst_valid (inst_valid),
    .stall      (stall),
    .reg_write  (reg_write),
    .is_load    (is_load),
    .is_adsb    (is_adsb),
    .is_sub     (is_sub),
    .is_mult    (is_mult),
    .is_itof    (is_itof),
    .illegal    (illegal),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fop(input logic [6:0] f7,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b1010011};
  endfunction

  function automatic logic [31:0] flw(input logic [4:0] rd);
    return {12'd0, 5'd2, 3'b010, rd, 7'b0000111};
  endfunction

  function automatic logic [31:0] fsw(input logic [4:0] rs2);
    return {7'd0, rs2, 5'd2, 3'b010, 5'd0, 7'b0100111};
  endfunction

  localparam logic [6:0] ADD = 7'b0000000;
  localparam logic [6:0] SUB = 7'b0000100;
  localparam logic [6:0] MUL = 7'b0001000;
  localparam logic [6:0] MWX = 7'b1111000;
  localparam logic [6:0] MXW = 7'b1110000;
  localparam logic [6:0] BAD = 7'b0101100;

  // Present one vector for a whole cycle; return at the falling edge.
  task automatic present(input logic v, input logic [31:0] i);
    @(posedge clk);
    #1;
    inst_valid = v;
    inst       = i;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 6; k++) present(1'b0, 32'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    inst_valid = 1'b1;
    inst       = fop(ADD, 5'd3, 5'd1, 5'd2);
    repeat (2) @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_rw", reg_write, 1'b0);
    chk("rst_adsb", is_adsb, 1'b0);
    chk("rst_cnt", stall_cnt, 0);
    #1;
    rst        = 1'b0;
    inst_valid = 1'b0;

    // RAW on FADD result
    present(1'b1, fop(ADD, 5'd3, 5'd1, 5'd2));
    chk("raw_c0_stall", stall, 1'b0);
    chk("raw_c0_adsb", is_adsb, 1'b1);
    chk("raw_c0_rw", reg_write, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      present(1'b1, fop(MUL, 5'd4, 5'd3, 5'd1));
      chk("raw_stall", stall, 1'b1);
      chk("raw_bubble", is_mult, 1'b0);
    end
    present(1'b1, fop(MUL, 5'd4, 5'd3, 5'd1));
    chk("raw_c5_stall", stall, 1'b0);
    chk("raw_c5_mult", is_mult, 1'b1);
    chk("raw_cnt", stall_cnt, 4);
    drain();

    // FLW then dependent FSW
    present(1'b1, flw(5'd5));
    chk("flw_load", is_load, 1'b1);
    chk("flw_rw", reg_write, 1'b1);
    present(1'b0, 32'd0);
    chk("idle_stall", stall, 1'b0);
    chk("idle_rw", reg_write, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      present(1'b1, fsw(5'd5));
      chk("fsw_stall", stall, 1'b1);
    end
    present(1'b1, fsw(5'd5));
    chk("fsw_c5_stall", stall, 1'b0);
    chk("fsw_c5_rw", reg_write, 1'b0);
    chk("fsw_cnt", stall_cnt, 7);
    drain();

    // WAW reload
    present(1'b1, fop(ADD, 5'd7, 5'd1, 5'd2));
    present(1'b0, 32'd0);
    present(1'b1, fop(SUB, 5'd7, 5'd8, 5'd9));
    chk("waw_stall", stall, 1'b0);
    chk("waw_sub", is_sub, 1'b1);
    chk("waw_adsb", is_adsb, 1'b1);
    for (int c = 3; c <= 6; c++) begin
      present(1'b1, fop(MUL, 5'd10, 5'd7, 5'd8));
      chk("waw_hold", stall, 1'b1);
    end
    present(1'b1, fop(MUL, 5'd10, 5'd7, 5'd8));
    chk("waw_c7_stall", stall, 1'b0);
    chk("waw_c7_mult", is_mult, 1'b1);
    chk("waw_cnt", stall_cnt, 11);
    drain();

    // Illegal funct7 leaves the scoreboard alone
    present(1'b1, fop(BAD, 5'd12, 5'd12, 5'd12));
    chk("ill_flag", illegal, 1'b1);
    chk("ill_rw", reg_write, 1'b0);
    chk("ill_stall", stall, 1'b0);
    present(1'b1, fop(ADD, 5'd13, 5'd12, 5'd12));
    chk("ill_sb_stall", stall, 1'b0);
    chk("ill_sb_adsb", is_adsb, 1'b1);
    chk("ill_legal", illegal, 1'b0);

    // FMV.X.W reads rs1, writes no FP register
    present(1'b1, fop(MXW, 5'd1, 5'd13, 5'd0));
    chk("mxw_stall", stall, 1'b1);
    drain();
    present(1'b1, fop(MXW, 5'd1, 5'd13, 5'd0));
    chk("mxw_go", stall, 1'b0);
    chk("mxw_rw", reg_write, 1'b0);
    chk("mxw_ill", illegal, 1'b0);
    chk("mxw_cnt", stall_cnt, 12);

    // Reset while FMUL f9 is in flight
    present(1'b1, fop(MUL, 5'd9, 5'd1, 5'd2));
    present(1'b0, 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    inst_valid = 1'b1;
    inst       = fop(ADD, 5'd10, 5'd9, 5'd9);
    #2;
    chk("rstm_stall", stall, 1'b0);
    chk("rstm_rw", reg_write, 1'b0);
    chk("rstm_cnt", stall_cnt, 0);
    inst_valid = 1'b0;
    rst        = 1'b0;
    present(1'b1, fop(ADD, 5'd10, 5'd9, 5'd9));
    chk("rstp_stall", stall, 1'b0);
    chk("rstp_adsb", is_adsb, 1'b1);
    drain();

    // Independent stream, one issue per cycle
    for (int i = 0; i < 20; i++) begin
      logic [4:0] rd;
      rd = 5'(i + 1);
      case (i % 3)
        0: begin
          present(1'b1, fop(ADD, rd, 5'd31, 5'd31));
          chk("str_adsb", is_adsb, 1'b1);
        end
        1: begin
          present(1'b1, fop(MUL, rd, 5'd31, 5'd31));
          chk("str_mult", is_mult, 1'b1);
        end
        default: begin
          present(1'b1, fop(MWX, rd, 5'(i), 5'(i)));
          chk("str_itof", is_itof, 1'b1);
        end
      endcase
      chk("str_stall", stall, 1'b0);
      chk("str_rw", reg_write, 1'b1);
    end
    chk("str_cnt", stall_cnt, 0);

    present(1'b0, 32'd0);
    chk("end_idle_rw", reg_write, 1'b0);
    chk("end_idle_ill", illegal, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
